// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and the
// instruction memory (slave); a request completes in any cycle with memReq && memReady.
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  memReq;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memRdata;
  logic                  memReady;

  modport master (output memReq, output memAddr, input memRdata, input memReady);
  modport slave  (input memReq, input memAddr, output memRdata, output memReady);
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads words from instruction memory and strobes them into the IR.
// Optional feature FETCH_TIMEOUT_EN: halts with a sticky fetchErr when memory stalls too long.
module instruction_fetch_unit #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int RESET_PC       = 0,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   CLK,
  input  logic                   reset,
  instruction_fetch_unit_if.master mem,
  output logic [DATA_WIDTH-1:0]  instruction,
  output logic                   irWrite,
  input  logic                   advance,
  input  logic                   branchTaken,
  input  logic [ADDR_WIDTH-1:0]  branchTarget,
  output logic [ADDR_WIDTH-1:0]  pcOut,
  output logic [15:0]            fetchCount,
  output logic                   fetchErr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WRITE = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic                  mem_req_r;
  logic                  ir_write_r;
  logic [DATA_WIDTH-1:0] instr_r;
  logic [15:0]           fetch_cnt_r;
  logic                  adv_pend_r;
  logic                  br_pend_r;
  logic [ADDR_WIDTH-1:0] tgt_pend_r;
  logic                  take_s;
  logic [ADDR_WIDTH-1:0] tgt_s;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 32) ? 5 : $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_r;
  logic          err_r;
  assign fetchErr = err_r;
`else
  assign fetchErr = 1'b0;
`endif

  // Branch decision: an advance captured during S_WRITE uses the branch inputs seen with it.
  always_comb begin
    take_s = 1'b0;
    tgt_s  = '0;
    if (adv_pend_r) begin
      take_s = br_pend_r;
      tgt_s  = tgt_pend_r;
    end else begin
      take_s = branchTaken;
      tgt_s  = branchTarget;
    end
  end

  // Fetch sequencer with registered memory-request and IR-strobe outputs.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      pc_r        <= ADDR_WIDTH'(RESET_PC);
      mem_req_r   <= 1'b0;
      ir_write_r  <= 1'b0;
      instr_r     <= '0;
      fetch_cnt_r <= 16'd0;
      adv_pend_r  <= 1'b0;
      br_pend_r   <= 1'b0;
      tgt_pend_r  <= '0;
`ifdef FETCH_TIMEOUT_EN
      to_cnt_r    <= '0;
      err_r       <= 1'b0;
`endif
    end else begin
      ir_write_r <= 1'b0;
      adv_pend_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          state_r   <= S_REQ;
          mem_req_r <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
          to_cnt_r  <= '0;
`endif
        end
        S_REQ: begin
          if (mem.memReady) begin
            instr_r    <= mem.memRdata;
            ir_write_r <= 1'b1;
            mem_req_r  <= 1'b0;
            state_r    <= S_WRITE;
          end
`ifdef FETCH_TIMEOUT_EN
          // A ready on the last allowed cycle is handled above, so it wins over the timeout.
          else if (to_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
            mem_req_r <= 1'b0;
            err_r     <= 1'b1;
            state_r   <= S_HALT;
          end else begin
            to_cnt_r <= to_cnt_r + {{(TW-1){1'b0}}, 1'b1};
          end
`else
          else begin
            mem_req_r <= 1'b1;
          end
`endif
        end
        S_WRITE: begin
          pc_r        <= pc_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          fetch_cnt_r <= fetch_cnt_r + 16'd1;
          adv_pend_r  <= advance;
          br_pend_r   <= branchTaken;
          tgt_pend_r  <= branchTarget;
          state_r     <= S_EXEC;
        end
        S_EXEC: begin
          if (adv_pend_r || advance) begin
            if (take_s) begin
              pc_r <= tgt_s;
            end else begin
              pc_r <= pc_r;
            end
            mem_req_r <= 1'b1;
            state_r   <= S_REQ;
`ifdef FETCH_TIMEOUT_EN
            to_cnt_r  <= '0;
`endif
          end else begin
            state_r <= S_EXEC;
          end
        end
        S_HALT: begin
          mem_req_r <= 1'b0;
          state_r   <= S_HALT;
        end
        default: begin
          mem_req_r <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

  assign mem.memReq  = mem_req_r;
  assign mem.memAddr = pc_r;
  assign instruction = instr_r;
  assign irWrite     = ir_write_r;
  assign pcOut       = pc_r;
  assign fetchCount  = fetch_cnt_r;

endmodule
